// File: rtl/transform_arbiter.sv
// Round-robin burst arbiter sharing one Transform unit among N_REQ triangle producers, with
// ID-tagged return routing. Optional burst-lock timeout is enabled by defining TF_ARB_TIMEOUT_EN.
module transform_arbiter #(
  parameter int N_REQ      = 4,
  parameter int META_WIDTH = 1,
  parameter int DATA_W     = 32,
  parameter int RSP_W      = 32,
`ifdef TF_ARB_TIMEOUT_EN
  parameter int TIMEOUT    = 64,
`endif
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int MD_W      = ID_W + META_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [N_REQ-1:0][DATA_W-1:0]           req_s_data,
  input  logic [N_REQ-1:0][META_WIDTH-1:0]       req_s_metadata,
  input  logic [N_REQ-1:0]                       req_s_last,
  input  logic [N_REQ-1:0]                       req_s_valid,
  output logic [N_REQ-1:0]                       req_s_ready,
  output logic [DATA_W-1:0]                      tf_m_data,
  output logic [MD_W-1:0]                        tf_m_metadata,
  output logic                                   tf_m_valid,
  input  logic                                   tf_m_ready,
  input  logic [RSP_W-1:0]                       tf_s_data,
  input  logic [MD_W-1:0]                        tf_s_metadata,
  input  logic                                   tf_s_valid,
  output logic                                   tf_s_ready,
  output logic [N_REQ-1:0][RSP_W-1:0]            rsp_m_data,
  output logic [N_REQ-1:0][META_WIDTH-1:0]       rsp_m_metadata,
  output logic [N_REQ-1:0]                       rsp_m_valid,
  input  logic [N_REQ-1:0]                       rsp_m_ready,
  output logic                                   busy
);

  typedef enum logic {S_ARB = 1'b0, S_LOCK = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   pick, scan_idx, next_grant, rsp_id;
  logic              found, out_free, accept;
  logic              tf_m_valid_q, tf_m_valid_d;
  logic [DATA_W-1:0] tf_m_data_q, tf_m_data_d;
  logic [MD_W-1:0]   tf_m_meta_q, tf_m_meta_d;
`ifdef TF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
`endif

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (!found && req_s_valid[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  assign out_free   = !tf_m_valid_q || tf_m_ready;
  assign accept     = (state_q == S_LOCK) && req_s_valid[grant_id_q] && out_free;
  assign next_grant = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  always_comb begin
    req_s_ready = '0;
    if (state_q == S_LOCK) req_s_ready[grant_id_q] = out_free;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
`ifdef TF_ARB_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif
    case (state_q)
      S_ARB: begin
`ifdef TF_ARB_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (found) begin
          grant_id_d = pick;
          state_d    = S_LOCK;
        end
      end
      default: begin
        if (accept && req_s_last[grant_id_q]) begin
          rr_ptr_d = next_grant;
          state_d  = S_ARB;
        end
`ifdef TF_ARB_TIMEOUT_EN
        if (accept) begin
          idle_cnt_d = '0;
        end else if (!req_s_valid[grant_id_q]) begin
          // A stalled owner gives up the lock; its remaining beats start a new burst.
          if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            idle_cnt_d = '0;
            rr_ptr_d   = next_grant;
            state_d    = S_ARB;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
`endif
      end
    endcase
  end

  // Output register: reload on accept, otherwise drain on ready.
  always_comb begin
    tf_m_valid_d = tf_m_valid_q;
    tf_m_data_d  = tf_m_data_q;
    tf_m_meta_d  = tf_m_meta_q;
    if (accept) begin
      tf_m_valid_d = 1'b1;
      tf_m_data_d  = req_s_data[grant_id_q];
      tf_m_meta_d  = {grant_id_q, req_s_metadata[grant_id_q]};
    end else if (tf_m_ready) begin
      tf_m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_ARB;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      tf_m_valid_q <= 1'b0;
      tf_m_data_q  <= '0;
      tf_m_meta_q  <= '0;
`ifdef TF_ARB_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      tf_m_valid_q <= tf_m_valid_d;
      tf_m_data_q  <= tf_m_data_d;
      tf_m_meta_q  <= tf_m_meta_d;
`ifdef TF_ARB_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  assign tf_m_valid    = tf_m_valid_q;
  assign tf_m_data     = tf_m_data_q;
  assign tf_m_metadata = tf_m_meta_q;
  assign busy          = (state_q != S_ARB) || tf_m_valid_q;

  // Return path: route by the ID tag; unknown IDs are swallowed.
  assign rsp_id = tf_s_metadata[MD_W-1 -: ID_W];

  always_comb begin
    rsp_m_valid = '0;
    tf_s_ready  = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_m_data[i]     = tf_s_data;
      rsp_m_metadata[i] = tf_s_metadata[META_WIDTH-1:0];
      if (rsp_id == ID_W'(i)) begin
        rsp_m_valid[i] = tf_s_valid;
        tf_s_ready     = rsp_m_ready[i];
      end
    end
  end

endmodule
